// File: rtl/tagged_event_queue_if.sv
// Bus bundle for tagged_event_queue.
//   master: the side that produces events and pops them (stream registers / LLC)
//   slave : the queue itself
// Signals:
//   en, in_data, in_new, pop                    -> into the queue
//   out_valid, out_data, out_new, out_tag       <- head event
//   q_push_valid, q_pop_valid                   <- per-edge accept strobes
//   full, overflow                              <- registered status
//   level                                       <- occupancy, only with TEQ_LEVEL_EN
interface tagged_event_queue_if #(
  parameter int N_IN   = 2,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 8
);
  logic                     en;
  logic [N_IN*DATA_W-1:0]   in_data;
  logic [N_IN-1:0]          in_new;
  logic                     pop;
  logic                     out_valid;
  logic [N_IN*DATA_W-1:0]   out_data;
  logic [N_IN-1:0]          out_new;
  logic [TAG_W-1:0]         out_tag;
  logic                     q_push_valid;
  logic                     q_pop_valid;
  logic                     full;
  logic                     overflow;
`ifdef TEQ_LEVEL_EN
  logic [$clog2(DEPTH):0]   level;
`endif

  modport master (
    output en, in_data, in_new, pop,
    input  out_valid, out_data, out_new, out_tag,
    input  q_push_valid, q_pop_valid, full, overflow
`ifdef TEQ_LEVEL_EN
    , input level
`endif
  );

  modport slave (
    input  en, in_data, in_new, pop,
    output out_valid, out_data, out_new, out_tag,
    output q_push_valid, q_pop_valid, full, overflow
`ifdef TEQ_LEVEL_EN
    , output level
`endif
  );
endinterface

// File: rtl/tagged_event_queue.sv
// tagged_event_queue: circular event buffer between the input-stream registers
// and the low-level controller. Every enabled cycle with any in_new bit set is
// packed into one event {in_data, in_new, tag}; the LLC pops in order
// (first-word-fall-through). A push that finds the queue full with no pop is
// dropped and sets the sticky overflow flag.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset; release is synchronised internally
//   bus  - tagged_event_queue_if.slave (see interface file for signal list)
// Optional feature macro: TEQ_LEVEL_EN adds the registered occupancy output
// bus.level. Without it the level register is not built.
module tagged_event_queue #(
  parameter int N_IN   = 2,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 8
) (
  input logic                 clk,
  input logic                 rst,
  tagged_event_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = N_IN * DATA_W;

  // Assert asynchronously, release on the first edge after rst rises, so the
  // first push can land on the second edge.
  logic rst_sync_q;
  logic rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= 1'b0;
    else      rst_sync_q <= 1'b1;
  end
  assign rst_n = rst_sync_q;

  // Pointers carry one wrap bit above the index bits.
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [AW:0]      occ_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             empty;
  logic             push_req;
  logic             pop_acc;
  logic             push_acc;

  logic [DW-1:0]    mem_data_q [DEPTH];
  logic [N_IN-1:0]  mem_new_q  [DEPTH];
  logic [TAG_W-1:0] mem_tag_q  [DEPTH];

  always_comb begin
    empty    = (wptr_q == rptr_q);
    push_req = rst_n && bus.en && (|bus.in_new);
    pop_acc  = rst_n && bus.en && bus.pop && !empty;
    // A full queue still takes the push when the head leaves on the same edge.
    push_acc = push_req && (!full_q || pop_acc);

    wptr_d = wptr_q;
    rptr_d = rptr_q;
    tag_d  = tag_q;
    ovf_d  = ovf_q;
    if (push_acc) begin
      wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
      tag_d  = tag_q + {{(TAG_W-1){1'b0}}, 1'b1};
    end
    if (pop_acc) begin
      rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (push_req && !push_acc) begin
      ovf_d = 1'b1;
    end
    occ_d  = wptr_d - rptr_d;
    full_d = (occ_d == (AW+1)'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      tag_q  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      tag_q  <= tag_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

  // Storage is not reset; the head read is masked while empty instead.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_data_q[wptr_q[AW-1:0]] <= bus.in_data;
      mem_new_q[wptr_q[AW-1:0]]  <= bus.in_new;
      mem_tag_q[wptr_q[AW-1:0]]  <= tag_q;
    end
  end

`ifdef TEQ_LEVEL_EN
  logic [AW:0] level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= '0;
    else        level_q <= occ_d;
  end
  assign bus.level = level_q;
`endif

  assign bus.out_valid    = !empty;
  assign bus.out_data     = empty ? '0 : mem_data_q[rptr_q[AW-1:0]];
  assign bus.out_new      = empty ? '0 : mem_new_q[rptr_q[AW-1:0]];
  assign bus.out_tag      = empty ? '0 : mem_tag_q[rptr_q[AW-1:0]];
  assign bus.q_push_valid = push_acc;
  assign bus.q_pop_valid  = pop_acc;
  assign bus.full         = full_q;
  assign bus.overflow     = ovf_q;
endmodule

// File: tb/tb_tagged_event_queue.sv
module tb_tagged_event_queue;
  localparam int N_IN   = 2;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 8;
  localparam int TAG_W  = 8;
  localparam int DW     = N_IN * DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tagged_event_queue_if #(.N_IN(N_IN), .DATA_W(DATA_W), .DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  tagged_event_queue #(.N_IN(N_IN), .DATA_W(DATA_W), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of events plus a free-running tag.
  typedef struct packed {
    logic [DW-1:0]    d;
    logic [N_IN-1:0]  n;
    logic [TAG_W-1:0] t;
  } ev_t;

  ev_t         mq[$];
  int unsigned m_tag;
  bit          m_ovf;
  bit          m_ready;

  task automatic model_clear();
    mq.delete();
    m_tag   = 0;
    m_ovf   = 0;
    m_ready = 0;
  endtask

  task automatic check_state();
    chk("out_valid", 256'(bus.out_valid), 256'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_data", 256'(bus.out_data), 256'(mq[0].d));
      chk("out_new",  256'(bus.out_new),  256'(mq[0].n));
      chk("out_tag",  256'(bus.out_tag),  256'(mq[0].t));
    end
    chk("full",     256'(bus.full),     256'(mq.size() == DEPTH));
    chk("overflow", 256'(bus.overflow), 256'(m_ovf));
`ifdef TEQ_LEVEL_EN
    chk("level", 256'(bus.level), 256'(mq.size()));
`endif
  endtask

  // Called just after a falling edge: drive, check strobes, clock, check state.
  task automatic cycle(input logic en, input logic [DW-1:0] d, input logic [N_IN-1:0] nw,
                       input logic pp, output logic spv, output logic sqv);
    bit  preq, pok, wok;
    ev_t e;
    bus.en      = en;
    bus.in_data = d;
    bus.in_new  = nw;
    bus.pop     = pp;
    preq = m_ready && (en == 1'b1) && (nw != '0);
    pok  = m_ready && (en == 1'b1) && (pp == 1'b1) && (mq.size() != 0);
    wok  = preq && ((mq.size() < DEPTH) || pok);
    #1;
    spv = bus.q_push_valid;
    sqv = bus.q_pop_valid;
    chk("q_push_valid", 256'(spv), 256'(wok));
    chk("q_pop_valid",  256'(sqv), 256'(pok));
    @(posedge clk);
    if (pok) void'(mq.pop_front());
    if (wok) begin
      e.d = d; e.n = nw; e.t = TAG_W'(m_tag);
      mq.push_back(e);
      m_tag = (m_tag + 1) % (1 << TAG_W);
    end else if (preq) begin
      m_ovf = 1;
    end
    if (rst) m_ready = 1;
    #1;
    check_state();
    @(negedge clk);
  endtask

  task automatic do_reset();
    logic spv, sqv;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
    chk("rst_full",      256'(bus.full),      256'(0));
    chk("rst_overflow",  256'(bus.overflow),  256'(0));
    chk("rst_out_tag",   256'(bus.out_tag),   256'(0));
    chk("rst_out_data",  256'(bus.out_data),  256'(0));
    chk("rst_out_new",   256'(bus.out_new),   256'(0));
`ifdef TEQ_LEVEL_EN
    chk("rst_level", 256'(bus.level), 256'(0));
`endif
    model_clear();
    bus.en = 1'b0; bus.in_new = '0; bus.pop = 1'b0; bus.in_data = '0;
    @(negedge clk);
    rst = 1'b1;
    // First edge after release must not accept a push yet.
    cycle(1'b1, '1, '1, 1'b1, spv, sqv);
  endtask

  typedef struct {
    bit               rst_before;
    logic             en;
    logic [DATA_W-1:0] d1, d0;
    logic [N_IN-1:0]  nw;
    logic             pp;
    logic             e_pv, e_qv, e_valid;
    logic [TAG_W-1:0] e_tag;
    logic             e_full, e_ovf;
  } vec_t;

  function automatic vec_t mk(bit r, logic en, logic [DATA_W-1:0] d1, logic [DATA_W-1:0] d0,
                              logic [N_IN-1:0] nw, logic pp, logic pv, logic qv, logic v,
                              logic [TAG_W-1:0] t, logic f, logic o);
    vec_t x;
    x.rst_before = r; x.en = en; x.d1 = d1; x.d0 = d0; x.nw = nw; x.pp = pp;
    x.e_pv = pv; x.e_qv = qv; x.e_valid = v; x.e_tag = t; x.e_full = f; x.e_ovf = o;
    return x;
  endfunction

  vec_t tbl[16];

  initial begin
    logic spv, sqv;
    logic [DW-1:0] rd;
    int hi;

    bus.en = 1'b0; bus.in_data = '0; bus.in_new = '0; bus.pop = 1'b0;
    model_clear();

    // Single push/pop, then fill to full, overflow, push+pop on full, en low.
    tbl[0] = mk(1, 1, 64'd7, 64'd3, 2'b01, 0, 1, 0, 1, 8'd0, 0, 0);
    tbl[1] = mk(0, 1, 64'd0, 64'd0, 2'b00, 1, 0, 1, 0, 8'd0, 0, 0);
    for (int i = 0; i < 8; i++)
      tbl[2+i] = mk(i == 0, 1, 64'(100 + i), 64'(i), 2'b11, 0, 1, 0, 1, 8'd0, i == 7, 0);
    tbl[10] = mk(0, 1, 64'd9, 64'd9, 2'b11, 0, 0, 0, 1, 8'd0, 1, 1);
    tbl[11] = mk(0, 1, 64'd50, 64'd51, 2'b10, 1, 1, 1, 1, 8'd1, 1, 1);
    for (int i = 0; i < 4; i++)
      tbl[12+i] = mk(0, 0, 64'hdead, 64'hbeef, 2'b11, 1, 0, 0, 1, 8'd1, 1, 1);

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].rst_before) do_reset();
      cycle(tbl[i].en, {tbl[i].d1, tbl[i].d0}, tbl[i].nw, tbl[i].pp, spv, sqv);
      chk($sformatf("vec%0d_pv", i), 256'(spv), 256'(tbl[i].e_pv));
      chk($sformatf("vec%0d_qv", i), 256'(sqv), 256'(tbl[i].e_qv));
      chk($sformatf("vec%0d_valid", i), 256'(bus.out_valid), 256'(tbl[i].e_valid));
      if (tbl[i].e_valid)
        chk($sformatf("vec%0d_tag", i), 256'(bus.out_tag), 256'(tbl[i].e_tag));
      chk($sformatf("vec%0d_full", i), 256'(bus.full), 256'(tbl[i].e_full));
      chk($sformatf("vec%0d_ovf", i), 256'(bus.overflow), 256'(tbl[i].e_ovf));
      if (i == 0) chk("vec0_data", 256'(bus.out_data), {128'd0, 64'd7, 64'd3});
    end

    // Drain: heads after each pop are tags 2..8 (8 came from the push on full).
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, '0, '0, 1'b1, spv, sqv);
      if (k < 7) chk("drain_tag", 256'(bus.out_tag), 256'(k + 2));
      else       chk("drain_empty", 256'(bus.out_valid), 256'(0));
    end

    // 300 push/pop pairs: head stays valid, tags wrap through 255 -> 0.
    do_reset();
    cycle(1'b1, {64'd1, 64'd2}, 2'b11, 1'b0, spv, sqv);
    for (int i = 0; i < 300; i++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      cycle(1'b1, rd, 2'($urandom_range(1, 3)), 1'b1, spv, sqv);
      chk("pair_valid", 256'(bus.out_valid), 256'(1));
    end
    chk("pair_wrap_tag", 256'(bus.out_tag), 256'(44));

    // Reset with 5 entries queued, then the next push restarts at tag 0.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'(i + 10), 2'b01, 1'b0, spv, sqv);
    do_reset();
    cycle(1'b1, {64'd5, 64'd6}, 2'b10, 1'b0, spv, sqv);
    chk("post_rst_valid", 256'(bus.out_valid), 256'(1));
    chk("post_rst_tag",   256'(bus.out_tag),   256'(0));

    // Random traffic with alternating pop pressure to hit full and empty.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      hi = ((i / 150) % 2 == 1) ? 75 : 30;
      rd = {$urandom, $urandom, $urandom, $urandom};
      cycle(($urandom_range(0, 7) != 0), rd, 2'($urandom), ($urandom_range(0, 99) < hi), spv, sqv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
